// File: rtl/norm_pkg.sv
// norm_pkg
// Shared types and constants for the normalizer frame sequencer.
//   seq_state_t   : per-frame sequencer states
//   DEFAULT_DENOM : denominator used after reset and whenever the crop
//                   filter reports a zero max pixel (avoids divide-by-zero)
package norm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CROP_START,
        CROP_WAIT,
        NORM_ARM,
        NORM_EN,
        NORM_RUN,
        DONE
    } seq_state_t;

    localparam int DEFAULT_DENOM = 1;

endpackage

// File: rtl/norm_seq_watchdog.sv
// norm_seq_watchdog
// Idle-cycle up-counter for the normalizer stream. The counter is cleared
// (loaded with zero) by 'clear', advances by one on 'count_en', and flags
// 'terminal' while it holds TIMEOUT_CYCLES-1.
// Ports:
//   clk       in  clock
//   srst      in  asynchronous active-high reset
//   clear     in  load zero (has priority over count_en)
//   count_en  in  increment by one
//   terminal  out count == TIMEOUT_CYCLES-1
module norm_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);

    logic [WDOG_W-1:0] count;

    // Idle counter: clearing wins so a beat in the same cycle restarts the
    // timeout window instead of extending the old one.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + WDOG_W'(1);
        end
    end

    // Terminal flag is evaluated on the current count, so the owner sees it
    // during the last permitted idle cycle.
    assign terminal = (count == WDOG_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/norm_frame_sequencer.sv
// norm_frame_sequencer
// Per-frame controller for the crop-filter -> normalizer pipeline. Starts the
// crop filter, latches the frame max pixel as the normalization denominator,
// arms and enables the normalizer, counts output beats up to the frame size
// and reports completion. A watchdog ends a frame whose stream stalls.
// Ports:
//   clk, srst         clock, asynchronous active-high reset
//   start, abort      frame request pulse (IDLE only) / soft abort to IDLE
//   cfg_continuous    auto-restart after DONE
//   cfg_pixels        beats per frame, captured in CROP_START
//   cf_ap_start       crop filter start pulse
//   cf_ap_done        crop filter done pulse, qualifies cf_max_valid/pixel
//   nr_ap_start       normalizer arm pulse
//   nr_cf_done        normalizer stream-enable pulse
//   norm_denominator  registered denominator
//   out_beat          normalizer output handshake
//   busy              state != IDLE
//   frame_done        end-of-frame pulse
//   timeout_err       sticky stall flag, cleared by srst or an accepted start
//   frame_count       completed frames (wraps)
module norm_frame_sequencer
    import norm_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int CNT_W           = 24,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_continuous,
    input  logic [CNT_W-1:0]           cfg_pixels,
    output logic                       cf_ap_start,
    input  logic                       cf_ap_done,
    input  logic                       cf_max_valid,
    input  logic [PIXEL_BIT_WIDTH-1:0] cf_max_pixel,
    output logic                       nr_ap_start,
    output logic                       nr_cf_done,
    output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
    input  logic                       out_beat,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       timeout_err,
    output logic [15:0]                frame_count
);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] pix_target;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_beat;
    logic             wdog_clear;
    logic             wdog_inc;
    logic             wdog_tc;

    assign last_beat = out_beat && (beat_cnt == pix_target - CNT_W'(1));

    // The watchdog only measures idle time inside NORM_RUN; every beat, the
    // NORM_EN setup cycle and an abort restart its window.
    assign wdog_clear = abort || (state == NORM_EN) || ((state == NORM_RUN) && out_beat);
    assign wdog_inc   = (state == NORM_RUN) && !out_beat;

    norm_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .srst     (srst),
        .clear    (wdog_clear),
        .count_en (wdog_inc),
        .terminal (wdog_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort overrides everything, including a start that
    // arrives in the same cycle.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:       if (start) next_state = CROP_START;
                CROP_START: next_state = CROP_WAIT;
                CROP_WAIT:  if (cf_ap_done) next_state = NORM_ARM;
                NORM_ARM:   next_state = NORM_EN;
                NORM_EN:    next_state = (pix_target == '0) ? DONE : NORM_RUN;
                NORM_RUN: begin
                    if (last_beat || (!out_beat && wdog_tc)) begin
                        next_state = DONE;
                    end
                end
                DONE:       next_state = cfg_continuous ? CROP_START : IDLE;
                default:    next_state = IDLE;
            endcase
        end
    end

    // Frame datapath: target capture, beat counting, denominator latch,
    // sticky timeout and completed-frame counter. Abort only clears the beat
    // counter; results of earlier frames are preserved.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            pix_target       <= '0;
            beat_cnt         <= '0;
            norm_denominator <= PIXEL_BIT_WIDTH'(DEFAULT_DENOM);
            timeout_err      <= 1'b0;
            frame_count      <= '0;
        end else if (abort) begin
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) timeout_err <= 1'b0;
                end
                CROP_START: begin
                    pix_target <= cfg_pixels;
                end
                CROP_WAIT: begin
                    if (cf_ap_done && cf_max_valid) begin
                        norm_denominator <= (cf_max_pixel == '0) ?
                                            PIXEL_BIT_WIDTH'(DEFAULT_DENOM) : cf_max_pixel;
                    end
                end
                NORM_EN: begin
                    beat_cnt <= '0;
                end
                NORM_RUN: begin
                    if (out_beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end else if (wdog_tc) begin
                        timeout_err <= 1'b1;
                    end
                end
                DONE: begin
                    frame_count <= frame_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake pulses and status are decoded straight from the state
    // register, so each pulse lasts exactly the one cycle spent in its state.
    assign cf_ap_start = (state == CROP_START);
    assign nr_ap_start = (state == NORM_ARM);
    assign nr_cf_done  = (state == NORM_EN);
    assign frame_done  = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_norm_frame_sequencer.sv
// tb_norm_frame_sequencer
// Self-checking bench for norm_frame_sequencer. Expected frame results are
// queued when the crop filter response is driven and compared when the DUT
// pulses frame_done. Inputs change on the falling edge; outputs are sampled
// on the falling edge.
module tb_norm_frame_sequencer;

    localparam int PW = 10;
    localparam int CW = 24;
    localparam int TO = 8;

    logic          clk;
    logic          srst;
    logic          start;
    logic          abort;
    logic          cfg_continuous;
    logic [CW-1:0] cfg_pixels;
    logic          cf_ap_start;
    logic          cf_ap_done;
    logic          cf_max_valid;
    logic [PW-1:0] cf_max_pixel;
    logic          nr_ap_start;
    logic          nr_cf_done;
    logic [PW-1:0] norm_denominator;
    logic          out_beat;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;
    logic [15:0]   frame_count;

    typedef struct {
        logic [PW-1:0] denom;
        logic          timeout;
        logic [15:0]   count;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          sb_head;
    int            checks      = 0;
    int            failures    = 0;
    int            done_pulses = 0;
    int            busy_drops  = 0;
    bit            watch_busy  = 0;
    logic [PW-1:0] exp_denom   = 10'd1;
    logic [15:0]   exp_frames  = 16'd0;

    norm_frame_sequencer #(
        .PIXEL_BIT_WIDTH(PW),
        .CNT_W(CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk              (clk),
        .srst             (srst),
        .start            (start),
        .abort            (abort),
        .cfg_continuous   (cfg_continuous),
        .cfg_pixels       (cfg_pixels),
        .cf_ap_start      (cf_ap_start),
        .cf_ap_done       (cf_ap_done),
        .cf_max_valid     (cf_max_valid),
        .cf_max_pixel     (cf_max_pixel),
        .nr_ap_start      (nr_ap_start),
        .nr_cf_done       (nr_cf_done),
        .norm_denominator (norm_denominator),
        .out_beat         (out_beat),
        .busy             (busy),
        .frame_done       (frame_done),
        .timeout_err      (timeout_err),
        .frame_count      (frame_count)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard side: every frame_done must match the oldest queued frame.
    // Also flags the two normalizer pulses overlapping and busy dropping
    // while a continuous run is being watched.
    always @(negedge clk) begin
        if (!srst) begin
            if (frame_done) begin
                done_pulses++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    sb_head = exp_q.pop_front();
                    checkOutput("sb_denom", norm_denominator, sb_head.denom);
                    checkOutput("sb_timeout", timeout_err, sb_head.timeout);
                    checkOutput("sb_count_before", frame_count, sb_head.count);
                end
            end
            if (nr_ap_start && nr_cf_done) begin
                checkOutput("nr_pulse_overlap", 32'd1, 32'd0);
            end
            if (watch_busy && !busy) begin
                busy_drops++;
            end
        end
    end

    // Absolute guard so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    // Called at an IDLE falling edge: request a frame and check the start
    // pulse one cycle later.
    task automatic startFrame(input int pixels);
        cfg_pixels = CW'(pixels);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("cf_ap_start_lat", cf_ap_start, 1);
        checkOutput("busy_on_start", busy, 1);
    endtask

    // Bounded wait for the crop filter start pulse (continuous restarts).
    task automatic waitCfStart();
        int n = 0;
        while (!cf_ap_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cf_ap_start_seen", cf_ap_start, 1);
    endtask

    // Called in CROP_START: answer as the crop filter, update the
    // denominator model, queue the frame's expected result, and check the
    // normalizer arm/enable pulses. Returns at the NORM_EN falling edge.
    task automatic applyStimulus(input logic [PW-1:0] maxp, input bit mvalid,
                                 input bit push, input bit to_exp, input int gap);
        @(negedge clk);
        checkOutput("cf_ap_start_pulse", cf_ap_start, 0);
        repeat (gap) @(negedge clk);
        if (mvalid) exp_denom = (maxp == '0) ? 10'd1 : maxp;
        if (push) exp_q.push_back('{denom: exp_denom, timeout: to_exp, count: exp_frames});
        cf_max_pixel = maxp;
        cf_max_valid = mvalid;
        cf_ap_done   = 1'b1;
        @(negedge clk);
        cf_ap_done   = 1'b0;
        cf_max_valid = 1'b0;
        checkOutput("nr_ap_start_lat", nr_ap_start, 1);
        checkOutput("denom", norm_denominator, exp_denom);
        @(negedge clk);
        checkOutput("nr_cf_done_lat", nr_cf_done, 1);
        checkOutput("nr_ap_start_pulse", nr_ap_start, 0);
    endtask

    // Called at the NORM_EN falling edge. 'stray' drives a beat while still in
    // NORM_EN, which must not be counted. Returns one cycle after last beat.
    task automatic driveBeats(input int n, input int maxgap, input bit stray);
        out_beat = stray;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            out_beat = 1'b0;
            repeat (gap) @(negedge clk);
            out_beat = 1'b1;
            @(negedge clk);
        end
        out_beat = 1'b0;
    endtask

    // Called at the cycle after the last beat: DONE must be showing.
    task automatic finishFrame();
        checkOutput("frame_done_lat", frame_done, 1);
        @(negedge clk);
        exp_frames = exp_frames + 16'd1;
        checkOutput("frame_done_pulse", frame_done, 0);
        checkOutput("frame_count", frame_count, exp_frames);
        checkOutput("busy_after_done", busy, cfg_continuous);
    endtask

    initial begin
        int base;
        srst = 1'b1; start = 1'b0; abort = 1'b0; cfg_continuous = 1'b0;
        cfg_pixels = '0; cf_ap_done = 1'b0; cf_max_valid = 1'b0;
        cf_max_pixel = '0; out_beat = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cf_ap_start", cf_ap_start, 0);
        checkOutput("rst_nr_ap_start", nr_ap_start, 0);
        checkOutput("rst_nr_cf_done", nr_cf_done, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_frame_count", frame_count, 0);
        checkOutput("rst_denom", norm_denominator, 1);
        srst = 1'b0;
        @(negedge clk);

        // 1: basic frame, 16 back-to-back beats
        startFrame(16);
        applyStimulus(10'd200, 1'b1, 1'b1, 1'b0, 2);
        driveBeats(16, 0, 1'b0);
        finishFrame();

        // 2: zero max pixel forces denominator 1, then an unqualified max is ignored
        startFrame(6);
        applyStimulus(10'd0, 1'b1, 1'b1, 1'b0, 0);
        driveBeats(6, 2, 1'b0);
        finishFrame();
        startFrame(6);
        applyStimulus(10'd555, 1'b0, 1'b1, 1'b0, 1);
        driveBeats(6, 2, 1'b0);
        finishFrame();

        // 3: stall after two of four beats trips the watchdog
        startFrame(4);
        applyStimulus(10'd50, 1'b1, 1'b1, 1'b1, 0);
        driveBeats(2, 0, 1'b0);
        repeat (TO - 1) @(negedge clk);
        checkOutput("timeout_early", timeout_err, 0);
        checkOutput("done_early", frame_done, 0);
        @(negedge clk);
        checkOutput("timeout_set", timeout_err, 1);
        finishFrame();
        checkOutput("timeout_sticky", timeout_err, 1);

        // 4: continuous mode, three frames with random beat gaps
        cfg_continuous = 1'b1;
        base = done_pulses;
        startFrame(8);
        checkOutput("timeout_cleared_by_start", timeout_err, 0);
        watch_busy = 1'b1;
        applyStimulus(10'd300, 1'b1, 1'b1, 1'b0, 0);
        driveBeats(8, 4, 1'b0);
        finishFrame();
        waitCfStart();
        applyStimulus(10'd0, 1'b1, 1'b1, 1'b0, 1);
        driveBeats(8, 4, 1'b0);
        finishFrame();
        waitCfStart();
        cfg_continuous = 1'b0;
        applyStimulus(10'd1023, 1'b1, 1'b1, 1'b0, 0);
        driveBeats(8, 4, 1'b0);
        watch_busy = 1'b0;
        finishFrame();
        checkOutput("cont_done_pulses", done_pulses - base, 3);
        checkOutput("cont_busy_drops", busy_drops, 0);

        // 5: abort mid-stream, abort racing start, then a full frame
        startFrame(10);
        applyStimulus(10'd321, 1'b1, 1'b0, 1'b0, 0);
        driveBeats(5, 1, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_no_done", frame_done, 0);
        checkOutput("abort_keeps_count", frame_count, exp_frames);
        checkOutput("abort_keeps_denom", norm_denominator, exp_denom);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_beats_start", busy, 0);
        startFrame(10);
        applyStimulus(10'd9, 1'b0, 1'b1, 1'b0, 0);
        driveBeats(10, 2, 1'b1);
        finishFrame();

        // 5b: asynchronous reset in the middle of CROP_WAIT
        startFrame(10);
        @(negedge clk);
        #2 srst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_denom", norm_denominator, 1);
        checkOutput("async_rst_count", frame_count, 0);
        exp_frames = 16'd0;
        exp_denom  = 10'd1;
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);

        // 6: counter wrap and an empty frame, with a start while busy
        force dut.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count;
        @(negedge clk);
        exp_frames = 16'hFFFF;
        checkOutput("preset_count", frame_count, 16'hFFFF);
        startFrame(0);
        applyStimulus(10'd64, 1'b1, 1'b1, 1'b0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finishFrame();
        checkOutput("busy_start_ignored", cf_ap_start, 0);

        checkOutput("sb_leftover", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
